hazard_unit: RTL and testbench

- Pipeline hazard responder for the 5-stage MIPS core; the counterpart to the pipelined controller.
- The controller issues decode-stage control and pipelines it to E/M/W. This block consumes the same decode-stage information and keeps its own shadow E/M/W copy of register-use state.
- From that state it returns stall, flush and forwarding-select signals to the datapath and the controller pipeline registers.
- Branch and jump redirects are resolved in M (pcsrc_m, jump_m).

---
 rtl/hazard_pkg.sv | 38 +++
 rtl/hazard_unit_if.sv | 37 +++
 rtl/hazard_fwd_sel.sv | 23 ++
 rtl/hazard_unit.sv | 109 ++++++++++
 tb/tb_hazard_unit.sv | 203 ++++++++++++++++++++
 5 files changed

// File: rtl/hazard_pkg.sv
// Shared types for the MIPS pipeline hazard unit: forwarding selects, shadow stage records
// and the helper that decides whether a stage's destination can create a hazard.
package hazard_pkg;

   // Widest register index the shadow records hold; narrower indices are zero-extended.
   localparam int unsigned REG_IDX_W = 8;

   typedef enum logic [1:0] {
      FWD_RF  = 2'b00,
      FWD_WB  = 2'b01,
      FWD_MEM = 2'b10
   } fwd_sel_t;

   typedef struct packed {
      logic                 valid;
      logic                 regwrite;
      logic                 memtoreg;
      logic                 uses_rs;
      logic                 uses_rt;
      logic [REG_IDX_W-1:0] rs;
      logic [REG_IDX_W-1:0] rt;
      logic [REG_IDX_W-1:0] writereg;
   } stage_info_t;

   typedef struct packed {
      logic                 valid;
      logic                 regwrite;
      logic [REG_IDX_W-1:0] writereg;
   } wb_info_t;

   function automatic logic live(input logic                 valid,
                                 input logic                 regwrite,
                                 input logic [REG_IDX_W-1:0] writereg,
                                 input logic                 r0_hardwired);
      return valid && regwrite && !(r0_hardwired && (writereg == '0));
   endfunction

endpackage

// File: rtl/hazard_unit_if.sv
// Decode-stage register-use info and M-stage redirects in; stall/flush/forward selects out.
interface hazard_unit_if
   import hazard_pkg::*;
#(
   parameter int unsigned REG_ADDR_W = 5
);
   logic                  valid_d;
   logic [REG_ADDR_W-1:0] rs_d;
   logic [REG_ADDR_W-1:0] rt_d;
   logic                  uses_rs_d;
   logic                  uses_rt_d;
   logic                  regwrite_d;
   logic                  memtoreg_d;
   logic [REG_ADDR_W-1:0] writereg_d;
   logic                  pcsrc_m;
   logic                  jump_m;

   logic                  stall_f;
   logic                  stall_d;
   logic                  flush_d;
   logic                  flush_e;
   fwd_sel_t              forward_ae;
   fwd_sel_t              forward_be;

   modport master (
      output valid_d, rs_d, rt_d, uses_rs_d, uses_rt_d, regwrite_d, memtoreg_d, writereg_d,
             pcsrc_m, jump_m,
      input  stall_f, stall_d, flush_d, flush_e, forward_ae, forward_be
   );

   modport slave (
      input  valid_d, rs_d, rt_d, uses_rs_d, uses_rt_d, regwrite_d, memtoreg_d, writereg_d,
             pcsrc_m, jump_m,
      output stall_f, stall_d, flush_d, flush_e, forward_ae, forward_be
   );

endinterface

// File: rtl/hazard_fwd_sel.sv
// Forwarding select for one E-stage ALU operand; the M-stage producer wins over W.
module hazard_fwd_sel
   import hazard_pkg::*;
(
   input  logic                 src_used_i,
   input  logic [REG_IDX_W-1:0] src_i,
   input  logic                 mem_live_i,
   input  logic [REG_IDX_W-1:0] mem_wr_i,
   input  logic                 wb_live_i,
   input  logic [REG_IDX_W-1:0] wb_wr_i,
   output fwd_sel_t             sel_o
);

   always_comb begin
      sel_o = FWD_RF;
      if (src_used_i && mem_live_i && (mem_wr_i == src_i)) begin
         sel_o = FWD_MEM;
      end else if (src_used_i && wb_live_i && (wb_wr_i == src_i)) begin
         sel_o = FWD_WB;
      end
   end

endmodule

// File: rtl/hazard_unit.sv
// Hazard unit for the 5-stage MIPS core: shadow E/M/W register-use state, stall/flush/forward.
// HAZARD_FORWARD_EN enables forwarding with load-use stalls; otherwise every RAW stalls until W.
module hazard_unit
   import hazard_pkg::*;
#(
   parameter int unsigned REG_ADDR_W   = 5,
   parameter bit          R0_HARDWIRED = 1'b1
) (
   input logic          clk,
   input logic          reset,
   hazard_unit_if.slave hz
);

   stage_info_t e_q, e_d;
   wb_info_t    m_q, m_d, w_q, w_d;

   logic [REG_ADDR_W-1:0] rs_raw, rt_raw, wr_raw;
   logic [REG_IDX_W-1:0]  d_rs, d_rt, d_wr;

   logic e_live, m_live;
   logic rs_hit_e, rt_hit_e;
   logic hz_stall, redirect, flush_e;

   assign rs_raw = hz.rs_d;
   assign rt_raw = hz.rt_d;
   assign wr_raw = hz.writereg_d;
   assign d_rs   = REG_IDX_W'(rs_raw);
   assign d_rt   = REG_IDX_W'(rt_raw);
   assign d_wr   = REG_IDX_W'(wr_raw);

   assign e_live   = live(e_q.valid, e_q.regwrite, e_q.writereg, R0_HARDWIRED);
   assign m_live   = live(m_q.valid, m_q.regwrite, m_q.writereg, R0_HARDWIRED);
   assign rs_hit_e = hz.uses_rs_d && (d_rs == e_q.writereg);
   assign rt_hit_e = hz.uses_rt_d && (d_rt == e_q.writereg);

`ifdef HAZARD_FORWARD_EN
   logic w_live;
   assign w_live   = live(w_q.valid, w_q.regwrite, w_q.writereg, R0_HARDWIRED);
   assign hz_stall = hz.valid_d && e_live && e_q.memtoreg && (rs_hit_e || rt_hit_e);

   hazard_fwd_sel u_fwd_a (
      .src_used_i (e_q.uses_rs),
      .src_i      (e_q.rs),
      .mem_live_i (m_live),
      .mem_wr_i   (m_q.writereg),
      .wb_live_i  (w_live),
      .wb_wr_i    (w_q.writereg),
      .sel_o      (hz.forward_ae)
   );

   hazard_fwd_sel u_fwd_b (
      .src_used_i (e_q.uses_rt),
      .src_i      (e_q.rt),
      .mem_live_i (m_live),
      .mem_wr_i   (m_q.writereg),
      .wb_live_i  (w_live),
      .wb_wr_i    (w_q.writereg),
      .sel_o      (hz.forward_be)
   );
`else
   logic rs_hit_m, rt_hit_m;
   logic unused_fwd_state;
   assign rs_hit_m = hz.uses_rs_d && (d_rs == m_q.writereg);
   assign rt_hit_m = hz.uses_rt_d && (d_rt == m_q.writereg);
   // Without forwarding, a producer in E or M blocks D; once in W the regfile write-first covers it.
   assign hz_stall = hz.valid_d && ((e_live && (rs_hit_e || rt_hit_e)) ||
                                    (m_live && (rs_hit_m || rt_hit_m)));
   assign hz.forward_ae = FWD_RF;
   assign hz.forward_be = FWD_RF;
   assign unused_fwd_state = ^{e_q.memtoreg, e_q.uses_rs, e_q.uses_rt, e_q.rs, e_q.rt, w_q};
`endif

   // Redirect is masked by reset so every output reads zero while reset is held.
   assign redirect   = reset && (hz.pcsrc_m || hz.jump_m);
   assign flush_e    = hz_stall || redirect;
   assign hz.stall_f = hz_stall && !redirect;
   assign hz.stall_d = hz_stall && !redirect;
   assign hz.flush_d = redirect;
   assign hz.flush_e = flush_e;

   always_comb begin
      e_d = '0;
      if (!flush_e) begin
         e_d.valid    = hz.valid_d;
         e_d.regwrite = hz.regwrite_d;
         e_d.memtoreg = hz.memtoreg_d;
         e_d.uses_rs  = hz.uses_rs_d;
         e_d.uses_rt  = hz.uses_rt_d;
         e_d.rs       = d_rs;
         e_d.rt       = d_rt;
         e_d.writereg = d_wr;
      end
      m_d = '{valid: e_q.valid, regwrite: e_q.regwrite, writereg: e_q.writereg};
      w_d = m_q;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         e_q <= '0;
         m_q <= '0;
         w_q <= '0;
      end else begin
         e_q <= e_d;
         m_q <= m_d;
         w_q <= w_d;
      end
   end

endmodule

// File: tb/tb_hazard_unit.sv
// Directed bench for hazard_unit; covers both HAZARD_FORWARD_EN builds and R0_HARDWIRED=0.
module tb_hazard_unit;
   import hazard_pkg::*;

`ifdef HAZARD_FORWARD_EN
   localparam bit FWD_EN = 1'b1;
`else
   localparam bit FWD_EN = 1'b0;
`endif

   // {stall_f, stall_d, flush_d, flush_e, forward_ae, forward_be}
   localparam logic [7:0] ST  = 8'b1101_0000;
   localparam logic [7:0] RD  = 8'b0011_0000;

   logic        clk = 1'b0;
   logic        rst_n;
   int unsigned vectors     = 0;
   int unsigned miscompares = 0;

   always #5 clk = ~clk;

   hazard_unit_if #(.REG_ADDR_W(5)) hz0 ();
   hazard_unit_if #(.REG_ADDR_W(5)) hz1 ();

   assign hz1.valid_d    = hz0.valid_d;
   assign hz1.rs_d       = hz0.rs_d;
   assign hz1.rt_d       = hz0.rt_d;
   assign hz1.uses_rs_d  = hz0.uses_rs_d;
   assign hz1.uses_rt_d  = hz0.uses_rt_d;
   assign hz1.regwrite_d = hz0.regwrite_d;
   assign hz1.memtoreg_d = hz0.memtoreg_d;
   assign hz1.writereg_d = hz0.writereg_d;
   assign hz1.pcsrc_m    = hz0.pcsrc_m;
   assign hz1.jump_m     = hz0.jump_m;

   hazard_unit #(.REG_ADDR_W(5), .R0_HARDWIRED(1'b1)) dut (
      .clk   (clk),
      .reset (rst_n),
      .hz    (hz0.slave)
   );

   hazard_unit #(.REG_ADDR_W(5), .R0_HARDWIRED(1'b0)) dut_r0 (
      .clk   (clk),
      .reset (rst_n),
      .hz    (hz1.slave)
   );

   function automatic logic [7:0] outs0();
      return {hz0.stall_f, hz0.stall_d, hz0.flush_d, hz0.flush_e,
              2'(hz0.forward_ae), 2'(hz0.forward_be)};
   endfunction

   function automatic logic [7:0] outs1();
      return {hz1.stall_f, hz1.stall_d, hz1.flush_d, hz1.flush_e,
              2'(hz1.forward_ae), 2'(hz1.forward_be)};
   endfunction

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   task automatic set_d(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                        input logic urs, input logic urt, input logic rw, input logic mtr,
                        input logic [4:0] wr);
      hz0.valid_d    = v;
      hz0.rs_d       = rs;
      hz0.rt_d       = rt;
      hz0.uses_rs_d  = urs;
      hz0.uses_rt_d  = urt;
      hz0.regwrite_d = rw;
      hz0.memtoreg_d = mtr;
      hz0.writereg_d = wr;
   endtask

   task automatic nop();
      set_d(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic sample();
      @(negedge clk);
   endtask

   task automatic idle(input int unsigned n);
      for (int unsigned i = 0; i < n; i++) begin
         tick();
         nop();
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation still running at %0t, required to finish earlier", $time);
      $fatal(1);
   end

   initial begin
      rst_n = 1'b0;
      nop();
      hz0.pcsrc_m = 1'b0;
      hz0.jump_m  = 1'b0;
      #2;
      chk("reset_outs", outs0(), 8'h00);
      chk("reset_outs_r0", outs1(), 8'h00);
      @(negedge clk);
      rst_n = 1'b1;

      // add $3,$1,$2 then sub $4,$3,$5
      tick(); set_d(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 1'b0, 5'd3);
      sample(); chk("add_in_d", outs0(), 8'h00);
      tick(); set_d(1'b1, 5'd3, 5'd5, 1'b1, 1'b1, 1'b1, 1'b0, 5'd4);
      sample(); chk("sub_in_d", outs0(), FWD_EN ? 8'h00 : ST);
`ifdef HAZARD_FORWARD_EN
      tick(); nop();
      sample(); chk("fwd_mem_a", outs0(), 8'b0000_1000);
`else
      tick();
      sample(); chk("raw_stall_2nd", outs0(), ST);
      tick();
      sample(); chk("raw_release_w", outs0(), 8'h00);
      tick(); nop();
      sample(); chk("nofwd_tied", outs0(), 8'h00);
`endif
      idle(3);

      // lw $2,0($1) then and $5,$2,$6
      tick(); set_d(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd2);
      sample(); chk("lw_in_d", outs0(), 8'h00);
      tick(); set_d(1'b1, 5'd2, 5'd6, 1'b1, 1'b1, 1'b1, 1'b0, 5'd5);
      sample(); chk("lw_use_stall", outs0(), ST);
`ifdef HAZARD_FORWARD_EN
      tick();
      sample(); chk("lw_stall_once", outs0() & 8'hF0, 8'h00);
      tick(); nop();
      sample(); chk("lw_fwd_wb", outs0(), 8'b0000_0100);
`else
      tick();
      sample(); chk("raw_lw_stall_2nd", outs0(), ST);
      tick();
      sample(); chk("raw_lw_release", outs0(), 8'h00);
      tick(); nop();
      sample(); chk("raw_lw_and_in_e", outs0(), 8'h00);
`endif
      idle(3);

      // producer writes $0, consumer reads $0
      tick(); set_d(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 1'b0, 5'd0);
      tick(); set_d(1'b1, 5'd0, 5'd7, 1'b1, 1'b1, 1'b1, 1'b0, 5'd8);
      sample();
      chk("r0_hw_d", outs0(), 8'h00);
      chk("r0_soft_d", outs1(), FWD_EN ? 8'h00 : ST);
      tick(); nop();
      sample();
      chk("r0_hw_e", outs0(), 8'h00);
      chk("r0_soft_e", outs1(), FWD_EN ? 8'b0000_1000 : 8'h00);
      idle(3);

      // taken branch in M coinciding with a load-use hazard
      tick(); set_d(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd2);
      tick(); set_d(1'b1, 5'd2, 5'd6, 1'b1, 1'b1, 1'b1, 1'b0, 5'd5);
      hz0.pcsrc_m = 1'b1;
      sample(); chk("redirect_over_stall", outs0(), RD);
      tick(); hz0.pcsrc_m = 1'b0;
      set_d(1'b1, 5'd5, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 5'd9);
      sample(); chk("flushed_e_bubble", outs0(), 8'h00);
      tick(); nop(); hz0.jump_m = 1'b1;
      sample(); chk("jump_flush", outs0(), RD);
      tick(); hz0.jump_m = 1'b0;
      idle(3);

      // three writers in flight, then asynchronous reset
      tick(); set_d(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd1);
      tick(); set_d(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd2);
      tick(); set_d(1'b1, 5'd1, 5'd2, FWD_EN, FWD_EN, 1'b1, 1'b0, 5'd3);
      tick(); set_d(1'b1, 5'd3, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 5'd4);
      hz0.pcsrc_m = 1'b1;
      sample(); chk("inflight_pre_reset", outs0(), FWD_EN ? 8'b0011_0110 : RD);
      #2 rst_n = 1'b0;
      #1;
      chk("async_reset", outs0(), 8'h00);
      chk("async_reset_r0", outs1(), 8'h00);
      nop();
      hz0.pcsrc_m = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      for (int unsigned i = 0; i < 3; i++) begin
         tick();
         sample(); chk("post_reset_idle", outs0(), 8'h00);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
